// File: rtl/classifier_ctrl_pkg.sv
// Shared constants and types for the pixel classifier control block.
package classifier_ctrl_pkg;

  localparam int NUM_THR   = 12;
  localparam int THR_W     = 9;
  localparam int NUM_CLS   = 5;
  localparam int CNT_WIDTH = 20;
  localparam int FRAME_W   = 16;

  localparam logic [4:0] ADDR_THR_LAST  = 5'd11;
  localparam logic [4:0] ADDR_CTRL      = 5'd12;
  localparam logic [4:0] ADDR_SNAP_BASE = 5'd16;
  localparam logic [4:0] ADDR_SNAP_LAST = 5'd20;
  localparam logic [4:0] ADDR_FRAME     = 5'd21;

  // sat, val, then lo/hi hue pairs for red, yellow, green, blue, pink
  localparam logic [THR_W-1:0] THR_DEFAULT [NUM_THR] = '{
    9'd153, 9'd127, 9'd30,  9'd330, 9'd50,  9'd70,
    9'd160, 9'd180, 9'd200, 9'd250, 9'd270, 9'd330
  };

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_RED    = 3'd1,
    CLS_YELLOW = 3'd2,
    CLS_GREEN  = 3'd3,
    CLS_BLUE   = 3'd4,
    CLS_PINK   = 3'd5
  } cls_e;

  typedef enum logic {
    ST_IDLE,
    ST_IN_FRAME
  } state_e;

endpackage

// File: rtl/classifier_ctrl_if.sv
// Register bus between a host and the classifier control block.
interface classifier_ctrl_if;
  logic [4:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_read;
  logic [31:0] s_readdata;

  modport master (output s_address, s_write, s_writedata, s_read, input s_readdata);
  modport slave  (input s_address, s_write, s_writedata, s_read, output s_readdata);
endinterface

// File: rtl/classifier_ctrl_class_stats.sv
// Per-class working pixel counters with saturation and end-of-frame snapshots.
module class_stats
  import classifier_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en_i,
  input  logic             restart_i,
  input  logic             snap_i,
  input  logic [2:0]       cls_i,
  output logic [CNT_W-1:0] snap_o [NUM_CLS]
);

  logic [CNT_W-1:0] work_q [NUM_CLS];
  logic [CNT_W-1:0] work_d [NUM_CLS];
  logic [CNT_W-1:0] snap_q [NUM_CLS];
  logic [CNT_W-1:0] snap_d [NUM_CLS];
  logic [CNT_W-1:0] next_cnt [NUM_CLS];

  // A restart drops the stale partial count but still counts its own pixel;
  // the snapshot therefore sees the count including the eop pixel.
  always_comb begin
    for (int k = 0; k < NUM_CLS; k++) begin
      next_cnt[k] = work_q[k];
      if (restart_i)
        next_cnt[k] = CNT_W'(count_en_i && (cls_i == 3'(k + 1)));
      else if (count_en_i && (cls_i == 3'(k + 1)) && (work_q[k] != '1))
        next_cnt[k] = work_q[k] + 1'b1;
      snap_d[k] = snap_i ? next_cnt[k] : snap_q[k];
      work_d[k] = snap_i ? '0 : next_cnt[k];
    end
  end

  // NOTE: state registers take non-blocking assignments only; all next-state
  // arithmetic stays in the always_comb above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CLS; k++) begin
        work_q[k] <= '0;
        snap_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CLS; k++) begin
        work_q[k] <= work_d[k];
        snap_q[k] <= snap_d[k];
      end
    end
  end

  assign snap_o = snap_q;

endmodule

// File: rtl/classifier_ctrl.sv
// Threshold register file with frame-aligned commit, frame FSM and class statistics.
module classifier_ctrl
  import classifier_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  classifier_ctrl_if.slave          bus,
  input  logic                      cls_valid,
  input  logic                      cls_sop,
  input  logic                      cls_eop,
  input  logic [2:0]                pixel_classification,
  output logic [NUM_THR*THR_W-1:0]  classifier_config,
  output logic                      commit_pending
);

  state_e             state_q;
  logic               pending_q;
  logic [FRAME_W-1:0] frame_q;
  logic [31:0]        rdata_q;
  logic [31:0]        rdata_d;
  logic [THR_W-1:0]   shadow_q [NUM_THR];
  logic [THR_W-1:0]   active_q [NUM_THR];
  logic [CNT_W-1:0]   snap_cnt [NUM_CLS];

  logic in_frame, sop, eop, count_en, frame_end, ctrl_wr, shadow_wr, commit;
  logic unused_wdata;

  assign in_frame  = (state_q == ST_IN_FRAME);
  assign sop       = cls_valid && cls_sop;
  assign eop       = cls_valid && cls_eop;
  // Pixels seen in IDLE without a sop belong to no frame and are dropped.
  assign count_en  = cls_valid && (in_frame || cls_sop);
  assign frame_end = eop && (in_frame || cls_sop);
  assign ctrl_wr   = bus.s_write && (bus.s_address == ADDR_CTRL) && bus.s_writedata[0];
  assign shadow_wr = bus.s_write && (bus.s_address <= ADDR_THR_LAST);
  // A commit write landing on the eop cycle is honoured by that same eop.
  assign commit    = (pending_q && !in_frame && !sop) || ((pending_q || ctrl_wr) && frame_end);
  assign unused_wdata = ^bus.s_writedata[31:THR_W];

  always_comb begin
    rdata_d = '0;
    if (bus.s_address <= ADDR_THR_LAST)
      rdata_d = 32'(shadow_q[bus.s_address[3:0]]);
    else if (bus.s_address == ADDR_CTRL)
      rdata_d = {30'b0, in_frame, pending_q};
    else if (bus.s_address >= ADDR_SNAP_BASE && bus.s_address <= ADDR_SNAP_LAST)
      rdata_d = 32'(snap_cnt[bus.s_address[2:0]]);
    else if (bus.s_address == ADDR_FRAME)
      rdata_d = 32'(frame_q);
  end

  // NOTE: the threshold banks are reset element by element because they must
  // come out of reset holding the default thresholds, not zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      frame_q   <= '0;
      rdata_q   <= '0;
      for (int k = 0; k < NUM_THR; k++) begin
        shadow_q[k] <= THR_DEFAULT[k];
        active_q[k] <= THR_DEFAULT[k];
      end
    end else begin
      case (state_q)
        ST_IDLE:     if (sop && !cls_eop) state_q <= ST_IN_FRAME;
        ST_IN_FRAME: if (eop) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
      pending_q <= commit ? 1'b0 : (pending_q || ctrl_wr);
      if (frame_end) frame_q <= frame_q + 1'b1;
      if (bus.s_read) rdata_q <= rdata_d;
      if (shadow_wr) shadow_q[bus.s_address[3:0]] <= bus.s_writedata[THR_W-1:0];
      if (commit) begin
        for (int k = 0; k < NUM_THR; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  always_comb begin
    classifier_config = '0;
    for (int k = 0; k < NUM_THR; k++)
      classifier_config[THR_W*k +: THR_W] = active_q[k];
  end

  assign commit_pending = pending_q;
  assign bus.s_readdata = rdata_q;

  class_stats #(.CNT_W(CNT_W)) u_stats (
    .clk        (clk),
    .rst        (rst),
    .count_en_i (count_en),
    .restart_i  (sop),
    .snap_i     (frame_end),
    .cls_i      (pixel_classification),
    .snap_o     (snap_cnt)
  );

endmodule

// File: doc/classifier_ctrl.md
CLASSIFIER_CTRL -- requirements
Module: classifier_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  sole clock, rising edge.
REQ-002 SHALL expose: rst  input  1  asynchronous active-low reset (0 = reset).
REQ-003 SHALL expose: s_address  input  5  register word address.
REQ-004 SHALL expose: s_write  input  1  write strobe, single cycle.
REQ-005 SHALL expose: s_writedata  input  32  write data.
REQ-006 SHALL expose: s_read  input  1  read strobe, single cycle.
REQ-007 SHALL expose: s_readdata  output  32  read data, registered.
REQ-008 SHALL expose: cls_valid  input  1  classification qualifier, already aligned with the 2-cycle HSV pipeline delay.
REQ-009 SHALL expose: cls_sop  input  1  first pixel of frame, qualified by cls_valid.
REQ-010 SHALL expose: cls_eop  input  1  last pixel of frame, qualified by cls_valid.
REQ-011 SHALL expose: pixel_classification  input  3  class code, 0 to 5.
REQ-012 SHALL expose: classifier_config  output  108  active thresholds, 12 fields of 9 bits, field k at bits [9k+8:9k].
REQ-013 SHALL expose: commit_pending  output  1  shadow-to-active copy is pending.

Function
REQ-014 Addresses 0-11 SHALL be R/W shadow threshold registers, bits [8:0]; field order: sat, val, red lo, red hi, yellow lo, yellow hi, green lo, green hi, blue lo, blue hi, pink lo, pink hi.
REQ-015 Address 12 SHALL be CTRL: a write with bit0=1 sets pending; a read returns {30'b0, in_frame, pending}.
REQ-016 Addresses 16-20 SHALL be read-only snapshot counts for classes 1-5, 20 bits, zero-extended.
REQ-017 Address 21 SHALL be read-only frame_count, 16 bits, wrapping 0xFFFF to 0.
REQ-018 Reads of unmapped addresses SHALL return 0, and writes to read-only or unmapped addresses SHALL be ignored.
REQ-019 s_readdata SHALL be valid 1 cycle after s_read and hold its value until the next read.
REQ-020 The FSM SHALL have two states, IDLE and IN_FRAME: IDLE to IN_FRAME on cls_valid&cls_sop; IN_FRAME to IDLE on cls_valid&cls_eop; cls_sop&cls_eop together (1-pixel frame) remains IDLE.
REQ-021 classifier_config SHALL change only at a frame boundary: when pending, in IDLE with no cls_sop that cycle, or on the cls_eop cycle; the active copy updates at the next edge and pending clears.
REQ-022 A commit write coinciding with cls_eop SHALL apply on that eop.
REQ-023 A commit write while already pending SHALL have no further effect.
REQ-024 Shadow writes during pending SHALL be captured by the eventual commit.
REQ-025 Working counters SHALL increment per cls_valid pixel with class 1-5 and saturate at 0xFFFFF, and SHALL ignore class 0 and codes 6-7.
REQ-026 On cls_eop, working counts including the eop pixel SHALL copy to the snapshot registers, working counters SHALL clear, and frame_count SHALL increment.
REQ-027 A cls_sop while IN_FRAME (missing eop) SHALL clear the working counters without a snapshot, and the FSM SHALL remain IN_FRAME.
REQ-028 A snapshot read on the same cycle as the eop update SHALL return the old value.

Reset
REQ-029 On rst=0 the block SHALL reset immediately: shadow and active config to defaults 153, 127, 30, 330, 50, 70, 160, 180, 200, 250, 270, 330; pending=0; FSM=IDLE; all counts=0; s_readdata=0.
REQ-030 A reset asserted mid-frame SHALL discard partial counts, and the first pixel after release SHALL be ignored until the next cls_sop.

Structure
REQ-031 A shared header SHALL hold register addresses, the 12 default threshold constants, class codes 0-5, and the count width of 20.
REQ-032 The per-class working counters, snapshot registers and saturation SHALL be one sub-module, class_stats, instantiated once.

Verification
REQ-033 Release reset, then read addresses 0-11 -> values 153, 127, 30, 330, 50, 70, 160, 180, 200, 250, 270, 330, one cycle after each read.
REQ-034 Write addr 2=40 and CTRL=1 while IN_FRAME -> commit_pending=1 and classifier_config[26:18] stays 30 until eop, then reads 40 on the next cycle.
REQ-035 Write addr 2=40 and CTRL=1 while IDLE -> config updates 1 cycle later and pending=0.
REQ-036 Drive a frame of 10 pixels with classes 1,1,2,3,0,5,5,5,4,7 -> snapshots read 2,1,1,1,3 and frame_count=1.
REQ-037 Drive 2^20+5 class-1 pixels in one frame -> snapshot for class 1 reads 0xFFFFF.
REQ-038 Assert rst mid-frame with pending=1 -> all counts 0, pending=0, config at defaults, FSM IDLE.
